// File: rtl/modulation_multiplier_pkg.sv
// ---------------------------------------------------------------------------
// modulation_pkg : shared defaults and FSM state type for the multiplier
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package modulation_pkg;

  localparam int WIDTH_DEFAULT = 13;
  localparam int DEPTH_DEFAULT = 249;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mod_mult_state_t;

endpackage

`default_nettype wire

// File: rtl/modulation_multiplier_if.sv
// ---------------------------------------------------------------------------
// modulation_multiplier_if : sampler/operator inputs and PWM-side outputs
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface modulation_multiplier_if #(
  parameter int WIDTH = modulation_pkg::WIDTH_DEFAULT
);

  logic [7:0]       M;
  logic             START;
  logic [15:0]      IDX;
  logic [WIDTH-1:0] DUTY_IN;
  logic [WIDTH-1:0] PHASE_IN;
  logic             DIN_VALID;
  logic [WIDTH-1:0] DUTY_OUT;
  logic [WIDTH-1:0] PHASE_OUT;
  logic             DOUT_VALID;
  logic [7:0]       DOUT_ADDR;
  logic [15:0]      MOD_IDX;
  logic             BUSY;
  logic             OVERRUN;

  modport master (
    output M, START, IDX, DUTY_IN, PHASE_IN, DIN_VALID,
    input  DUTY_OUT, PHASE_OUT, DOUT_VALID, DOUT_ADDR, MOD_IDX, BUSY, OVERRUN
  );

  modport slave (
    input  M, START, IDX, DUTY_IN, PHASE_IN, DIN_VALID,
    output DUTY_OUT, PHASE_OUT, DOUT_VALID, DOUT_ADDR, MOD_IDX, BUSY, OVERRUN
  );

endinterface

`default_nettype wire

// File: rtl/modulation_duty_scaler.sv
// ---------------------------------------------------------------------------
// modulation_duty_scaler : 2-stage duty * (m+1) >> 8 with aligned phase/addr
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module modulation_duty_scaler #(
  parameter int WIDTH = 13
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_valid,
  input  wire logic [WIDTH-1:0] i_duty,
  input  wire logic [WIDTH-1:0] i_phase,
  input  wire logic [7:0]       i_m,
  input  wire logic [7:0]       i_addr,
  input  wire logic             i_bypass,
  output logic                  o_valid,
  output logic [WIDTH-1:0]      o_duty,
  output logic [WIDTH-1:0]      o_phase,
  output logic [7:0]            o_addr
);

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_duty_q, s1_duty_d;
  logic [WIDTH-1:0] s1_phase_q, s1_phase_d;
  logic [7:0]       s1_m_q, s1_m_d;
  logic [7:0]       s1_addr_q, s1_addr_d;
  logic             s1_bypass_q, s1_bypass_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_duty_q, s2_duty_d;
  logic [WIDTH-1:0] s2_phase_q, s2_phase_d;
  logic [7:0]       s2_addr_q, s2_addr_d;

  logic [8:0]       m_plus;
  logic [WIDTH+8:0] product;
  logic             prod_unused;

  // m+1 <= 256 keeps the top product bit clear, so the shifted result fits WIDTH
  assign m_plus      = {1'b0, s1_m_q} + 9'd1;
  assign product     = {9'd0, s1_duty_q} * {{WIDTH{1'b0}}, m_plus};
  assign prod_unused = ^{product[7:0], product[WIDTH+8]};

  always_comb begin
    s1_valid_d  = i_valid;
    s1_duty_d   = s1_duty_q;
    s1_phase_d  = s1_phase_q;
    s1_m_d      = s1_m_q;
    s1_addr_d   = s1_addr_q;
    s1_bypass_d = s1_bypass_q;
    s2_valid_d  = s1_valid_q;
    s2_duty_d   = s2_duty_q;
    s2_phase_d  = s2_phase_q;
    s2_addr_d   = s2_addr_q;
    if (i_valid) begin
      s1_duty_d   = i_duty;
      s1_phase_d  = i_phase;
      s1_m_d      = i_m;
      s1_addr_d   = i_addr;
      s1_bypass_d = i_bypass;
    end
    // data registers only load on valid so outputs hold between words
    if (s1_valid_q) begin
      s2_duty_d  = s1_bypass_q ? s1_duty_q : product[WIDTH+7:8];
      s2_phase_d = s1_phase_q;
      s2_addr_d  = s1_addr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_duty_q   <= '0;
      s1_phase_q  <= '0;
      s1_m_q      <= '0;
      s1_addr_q   <= '0;
      s1_bypass_q <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_duty_q   <= '0;
      s2_phase_q  <= '0;
      s2_addr_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_duty_q   <= s1_duty_d;
      s1_phase_q  <= s1_phase_d;
      s1_m_q      <= s1_m_d;
      s1_addr_q   <= s1_addr_d;
      s1_bypass_q <= s1_bypass_d;
      s2_valid_q  <= s2_valid_d;
      s2_duty_q   <= s2_duty_d;
      s2_phase_q  <= s2_phase_d;
      s2_addr_q   <= s2_addr_d;
    end
  end

  assign o_valid = s2_valid_q;
  assign o_duty  = s2_duty_q;
  assign o_phase = s2_phase_q;
  assign o_addr  = s2_addr_q;

endmodule

`default_nettype wire

// File: rtl/modulation_multiplier.sv
// ---------------------------------------------------------------------------
// modulation_multiplier : per-frame m latch, accept FSM and overrun flag
// Optional MODULATION_BYPASS_EN adds BYPASS (duty passed through unscaled).
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module modulation_multiplier
  import modulation_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  wire logic CLK,
  input  wire logic RST,
`ifdef MODULATION_BYPASS_EN
  input  wire logic BYPASS,
`endif
  modulation_multiplier_if.slave bus
);

  localparam logic [7:0] LAST_ADDR = 8'(DEPTH - 1);

  mod_mult_state_t state_q, state_d;
  logic [7:0]      m_q, m_d;
  logic [15:0]     mod_idx_q, mod_idx_d;
  logic [7:0]      count_q, count_d;
  logic            overrun_q, overrun_d;
  logic            bypass_w;
  logic            accept;
  logic            final_accept;
  logic            latch;

`ifdef MODULATION_BYPASS_EN
  logic bypass_q, bypass_d;
  assign bypass_w = bypass_q;
`else
  assign bypass_w = 1'b0;
`endif

  assign accept       = (state_q == RUN) && bus.DIN_VALID;
  assign final_accept = accept && (count_q == LAST_ADDR);

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    mod_idx_d = mod_idx_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    latch     = 1'b0;
`ifdef MODULATION_BYPASS_EN
    bypass_d  = bypass_q;
`endif
    unique case (state_q)
      IDLE: latch = bus.START;
      RUN: begin
        if (accept) count_d = count_q + 8'd1;
        // START landing on the last word opens the next frame instead of overrunning
        if (final_accept) begin
          state_d = IDLE;
          latch   = bus.START;
        end else if (bus.START) begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (latch) begin
      state_d   = RUN;
      m_d       = bus.M;
      mod_idx_d = bus.IDX;
      count_d   = 8'd0;
`ifdef MODULATION_BYPASS_EN
      bypass_d  = BYPASS;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      m_q       <= '0;
      mod_idx_q <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
`ifdef MODULATION_BYPASS_EN
      bypass_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      mod_idx_q <= mod_idx_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
`ifdef MODULATION_BYPASS_EN
      bypass_q  <= bypass_d;
`endif
    end
  end

  modulation_duty_scaler #(.WIDTH(WIDTH)) u_scaler (
    .clk      (CLK),
    .rst      (RST),
    .i_valid  (accept),
    .i_duty   (bus.DUTY_IN),
    .i_phase  (bus.PHASE_IN),
    .i_m      (m_q),
    .i_addr   (count_q),
    .i_bypass (bypass_w),
    .o_valid  (bus.DOUT_VALID),
    .o_duty   (bus.DUTY_OUT),
    .o_phase  (bus.PHASE_OUT),
    .o_addr   (bus.DOUT_ADDR)
  );

  assign bus.MOD_IDX = mod_idx_q;
  assign bus.BUSY    = (state_q == RUN);
  assign bus.OVERRUN = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_modulation_multiplier.sv
// ---------------------------------------------------------------------------
// tb_modulation_multiplier : directed frames with random data vs frame model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_modulation_multiplier;

  localparam int WIDTH = 13;
  localparam int DEPTH = 249;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bypass = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   vcount = 0;

  // frame-level reference state
  bit   r_busy, r_ovr, r_byp;
  int   r_m, r_idx, r_cnt;
  bit   d1_v, d2_v;
  int   d1_duty, d1_ph, d1_addr, d2_duty, d2_ph, d2_addr;
  int   h_duty, h_ph, h_addr;

  always #5 clk = ~clk;

  modulation_multiplier_if #(.WIDTH(WIDTH)) bus ();

  modulation_multiplier #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK    (clk),
    .RST    (rst),
`ifdef MODULATION_BYPASS_EN
    .BYPASS (bypass),
`endif
    .bus    (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input bit rs, input bit st, input int mv, input int idx,
                     input bit dv, input int duty, input int ph, input bit byp);
    bit acc;
    rst           = rs;
    bus.START     = st;
    bus.M         = 8'(mv);
    bus.IDX       = 16'(idx);
    bus.DIN_VALID = dv;
    bus.DUTY_IN   = WIDTH'(duty);
    bus.PHASE_IN  = WIDTH'(ph);
    bypass        = byp;
    if (rs) begin
      r_busy = 0; r_ovr = 0; r_byp = 0; r_m = 0; r_idx = 0; r_cnt = 0;
      d1_v = 0; d2_v = 0; h_duty = 0; h_ph = 0; h_addr = 0;
    end else begin
      acc = r_busy && dv;
      d2_v = d1_v; d2_duty = d1_duty; d2_ph = d1_ph; d2_addr = d1_addr;
      d1_v = acc;
      d1_duty = r_byp ? duty : (duty * (r_m + 1)) / 256;
      d1_ph = ph;
      d1_addr = r_cnt;
      if (!r_busy || (acc && r_cnt == DEPTH - 1)) begin
        r_busy = 0;
        if (st) begin
          r_busy = 1; r_m = mv; r_idx = idx; r_cnt = 0;
`ifdef MODULATION_BYPASS_EN
          r_byp = byp;
`endif
        end
      end else begin
        if (acc) r_cnt++;
        if (st) r_ovr = 1;
      end
      if (d2_v) begin
        h_duty = d2_duty; h_ph = d2_ph; h_addr = d2_addr;
      end
    end
    @(posedge clk);
    #1;
    if (bus.DOUT_VALID === 1'b1) vcount++;
    chk("dout_valid", 32'(bus.DOUT_VALID), 32'(rs ? 1'b0 : d2_v));
    chk("duty_out", 32'(bus.DUTY_OUT), h_duty);
    chk("phase_out", 32'(bus.PHASE_OUT), h_ph);
    chk("dout_addr", 32'(bus.DOUT_ADDR), h_addr);
    chk("busy", 32'(bus.BUSY), 32'(r_busy));
    chk("overrun", 32'(bus.OVERRUN), 32'(r_ovr));
    chk("mod_idx", 32'(bus.MOD_IDX), r_idx);
  endtask

  task automatic start(input int mv, input int idx, input bit byp);
    cyc(0, 1, mv, idx, 0, 0, 0, byp);
  endtask

  task automatic word(input int duty);
    cyc(0, 0, 0, 0, 1, duty, int'($urandom_range(0, 8191)), 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic int rnd();
    return int'($urandom_range(0, 8191));
  endfunction

  initial begin
    // reset state
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0);
    idle(2);

    // identity frame
    start(255, 7, 0);
    for (int i = 0; i < DEPTH; i++) word(i);
    idle(4);
    chk("identity_mod_idx", 32'(bus.MOD_IDX), 7);
    chk("identity_busy_fall", 32'(bus.BUSY), 0);

    // scaling m=127 and m=0
    start(127, 21, 0);
    word(4096);
    word(rnd());
    chk("scale_m127", 32'(bus.DUTY_OUT), 2048);
    for (int i = 2; i < DEPTH; i++) word(rnd());
    idle(3);
    start(0, 22, 0);
    word(8191);
    word(rnd());
    chk("scale_m0", 32'(bus.DUTY_OUT), 31);
    for (int i = 2; i < DEPTH; i++) word(rnd());
    idle(3);

    // gapped input
    start(int'($urandom_range(0, 255)), 33, 0);
    vcount = 0;
    for (int i = 0; i < DEPTH; i++) begin
      word(rnd());
      idle(1);
    end
    idle(4);
    chk("gap_pulses", vcount, DEPTH);

    // overrun at count 100
    start(200, 44, 0);
    for (int i = 0; i < 100; i++) word(rnd());
    cyc(0, 1, 10, 99, 1, rnd(), rnd(), 0);
    chk("overrun_set", 32'(bus.OVERRUN), 1);
    for (int i = 101; i < DEPTH; i++) word(rnd());
    idle(6);
    chk("overrun_sticky", 32'(bus.OVERRUN), 1);
    chk("overrun_idx_kept", 32'(bus.MOD_IDX), 44);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    chk("overrun_cleared", 32'(bus.OVERRUN), 0);

    // START coincident with final accept
    start(50, 55, 0);
    for (int i = 0; i < DEPTH - 1; i++) word(rnd());
    cyc(0, 1, 250, 56, 1, 8000, rnd(), 0);
    chk("boundary_busy", 32'(bus.BUSY), 1);
    chk("boundary_no_overrun", 32'(bus.OVERRUN), 0);
    word(rnd());
    chk("boundary_last_old_m", 32'(bus.DUTY_OUT), (8000 * 51) / 256);
    for (int i = 1; i < DEPTH; i++) word(rnd());
    idle(4);

    // reset mid-frame
    start(80, 66, 0);
    for (int i = 0; i < 50; i++) word(rnd());
    cyc(1, 0, 0, 0, 1, rnd(), rnd(), 0);
    chk("rst_mid_busy", 32'(bus.BUSY), 0);
    chk("rst_mid_valid", 32'(bus.DOUT_VALID), 0);
    vcount = 0;
    for (int i = 0; i < 10; i++) word(rnd());
    idle(3);
    chk("rst_mid_no_output", vcount, 0);

`ifdef MODULATION_BYPASS_EN
    start(0, 77, 1);
    word(100);
    word(rnd());
    chk("bypass_duty", 32'(bus.DUTY_OUT), 100);
    for (int i = 2; i < DEPTH; i++) word(rnd());
    idle(4);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/modulation_multiplier.md
Name: modulation_multiplier

Overview:
- Sits directly downstream of the modulation sampler.
- Takes the sampler's 8-bit modulation value M, START pulse and sample index IDX, and applies M to the per-transducer duty stream coming from the normal/STM operator.
- Latches M once per frame on START, then scales DEPTH duty words, passes phases through, and emits an aligned valid stream toward the PWM stage.
- Flags START pulses that arrive while a frame is still in progress.

Parameters:
- WIDTH, 13, bit width of duty and phase words.
- DEPTH, 249, number of transducers (stream entries) per frame.

Ports:
- CLK  input  1  system clock; single clock domain.
- RST  input  1  reset; synchronous, active-high.
- M  input  8  modulation value from sampler.
- START  input  1  one-cycle pulse from sampler: new M/IDX valid this cycle.
- IDX  input  16  modulation sample index from sampler.
- DUTY_IN  input  WIDTH  per-transducer duty.
- PHASE_IN  input  WIDTH  per-transducer phase.
- DIN_VALID  input  1  DUTY_IN/PHASE_IN valid this cycle (no backpressure).
- DUTY_OUT  output  WIDTH  modulated duty.
- PHASE_OUT  output  WIDTH  delayed phase.
- DOUT_VALID  output  1  outputs valid.
- DOUT_ADDR  output  8  transducer index of current output word.
- MOD_IDX  output  16  IDX latched at the frame's START.
- BUSY  output  1  high while in RUN.
- OVERRUN  output  1  sticky: START arrived during RUN.

Behaviour:
- Reset: all outputs are 0, state is IDLE, latched m is 0, count is 0. Asserting reset mid-frame aborts the frame and flushes the pipeline valids to 0 on the next edge.
- FSM with two states:
  - IDLE: DIN_VALID is ignored. START latches m <= M and MOD_IDX <= IDX, sets count <= 0, and moves to RUN.
  - RUN: each DIN_VALID is accepted and increments count. When the accept has count == DEPTH-1, the FSM returns to IDLE.
- BUSY equals (state == RUN), registered.
- Simultaneous START and final accept in the same cycle: the final word is processed with the old m. START is then honoured: new m is latched and the FSM stays in RUN with count = 0. OVERRUN is not set.
- START in RUN at any other time: the START is ignored (m is unchanged) and OVERRUN is set. OVERRUN clears only on RST.
- Arithmetic: DUTY_OUT = (DUTY_IN * (m + 1)) >> 8.
  - Product is WIDTH+9 bits unsigned; the result always fits in WIDTH bits.
  - m = 255 gives identity; m = 0 gives DUTY_IN >> 8.
  - Truncation, no rounding.
- PHASE_OUT is PHASE_IN delayed to align with DUTY_OUT, unmodified.
- Latency: DOUT_VALID, DUTY_OUT, PHASE_OUT and DOUT_ADDR appear exactly 2 cycles after the accepting DIN_VALID cycle.
  - Stage 1 registers the inputs and m.
  - Stage 2 registers the product.
  - The pipeline is fully pipelined: back-to-back accepts give back-to-back outputs.
- DOUT_ADDR equals the count at accept time (0..DEPTH-1).
- DUTY_OUT, PHASE_OUT and DOUT_ADDR hold their last values when DOUT_VALID is low.

Optional Feature:
- MODULATION_BYPASS_EN defined: adds input port BYPASS (1 bit).
  - BYPASS is sampled together with m at START and held for the frame.
  - When set, DUTY_OUT = DUTY_IN unchanged; latency stays 2 cycles.
- Not defined: no BYPASS port, and scaling is always applied.

Decomposition:
- Package modulation_pkg holds:
  - localparams WIDTH_DEFAULT = 13 and DEPTH_DEFAULT = 249;
  - typedef enum logic {IDLE, RUN} mod_mult_state_t.
- One sub-module, modulation_duty_scaler: the 2-stage registered multiply (duty, m, phase, addr, valid in; aligned out). The top module holds the FSM, count, latches and OVERRUN.

Test Plan:
- Identity frame: RST, then START with M=255, IDX=7, then 249 consecutive DIN_VALID with DUTY_IN=i. Expect DUTY_OUT=i and DOUT_ADDR=i, each 2 cycles after input; MOD_IDX=7; BUSY falls after the last accept.
- Scaling: M=127, DUTY_IN=4096 -> DUTY_OUT=2048. M=0, DUTY_IN=8191 -> DUTY_OUT=31. PHASE_OUT equals PHASE_IN for each word.
- Gapped input: DIN_VALID toggles every other cycle over the frame. Outputs stay valid-aligned, with 249 DOUT_VALID pulses total and no drops.
- Overrun: START at count=100 with M=10. Expect OVERRUN=1, the remaining words still scaled by the old m, and OVERRUN held until RST.
- Boundary: START coincident with the final accept. Expect the last word scaled by the old m, the next frame scaled by the new m, BUSY staying 1, and OVERRUN=0.
- Reset mid-frame: RST at count=50. Next cycle: BUSY=0, DOUT_VALID=0 and no further outputs; DIN_VALID without START produces nothing. With MODULATION_BYPASS_EN: BYPASS=1, M=0, DUTY_IN=100 -> DUTY_OUT=100.
